// File: rtl/keccak_round_ctrl.sv
// Iterative Keccak-f[1600] sequencer: 1600-bit state register with UNROLL chained rounds per clock.
// Build option KECCAK_XOR_IN_EN: an IDLE accept XORs in_state into the retained state (sponge absorb).
module keccak_round_ctrl #(
  parameter int UNROLL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1599:0] in_state,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1599:0] out_state,
  output logic          busy,
  output logic [4:0]    round_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  typedef logic [63:0] lane_t;

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 ||
          UNROLL == 6 || UNROLL == 8 || UNROLL == 12)) begin : g_bad_unroll
      $error("keccak_round_ctrl: UNROLL=%0d illegal, must be 1,2,3,4,6,8 or 12", UNROLL);
    end
  endgenerate

  // Rho rotation offsets indexed by lane number 5*y+x.
  localparam int RHO [25] = '{ 0,  1, 62, 28, 27,
                              36, 44,  6, 55, 20,
                               3, 10, 43, 25, 39,
                              41, 45, 15, 21,  8,
                              18,  2, 61, 56, 14};

  function automatic lane_t rotl(input lane_t v, input int n);
    return (n == 0) ? v : ((v << n) | (v >> (64 - n)));
  endfunction

  // Compressed iota constants: bit i lands on lane(0,0) bit 2^i-1.
  function automatic logic [6:0] rc_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    rc_rom = 7'h01;
      5'd1:    rc_rom = 7'h1A;
      5'd2:    rc_rom = 7'h5E;
      5'd3:    rc_rom = 7'h70;
      5'd4:    rc_rom = 7'h1F;
      5'd5:    rc_rom = 7'h21;
      5'd6:    rc_rom = 7'h79;
      5'd7:    rc_rom = 7'h55;
      5'd8:    rc_rom = 7'h0E;
      5'd9:    rc_rom = 7'h0C;
      5'd10:   rc_rom = 7'h35;
      5'd11:   rc_rom = 7'h26;
      5'd12:   rc_rom = 7'h3F;
      5'd13:   rc_rom = 7'h4F;
      5'd14:   rc_rom = 7'h5D;
      5'd15:   rc_rom = 7'h53;
      5'd16:   rc_rom = 7'h52;
      5'd17:   rc_rom = 7'h48;
      5'd18:   rc_rom = 7'h16;
      5'd19:   rc_rom = 7'h66;
      5'd20:   rc_rom = 7'h79;
      5'd21:   rc_rom = 7'h58;
      5'd22:   rc_rom = 7'h21;
      5'd23:   rc_rom = 7'h74;
      default: rc_rom = 7'h00;
    endcase
  endfunction

  function automatic logic [1599:0] keccak_round(input logic [1599:0] s, input logic [6:0] rc);
    lane_t a [25];
    lane_t b [25];
    lane_t c [5];
    lane_t d [5];
    logic [1599:0] r;
    for (int i = 0; i < 25; i++) a[i] = s[1599-64*i -: 64];
    for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
    for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
    // Rho and pi together: lane (x,y) is rotated and moved to (y, 2x+3y).
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[5*((2*x+3*y)%5) + y] = rotl(a[5*y+x], RHO[5*y+x]);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[5*y+x] = b[5*y+x] ^ (~b[5*y+(x+1)%5] & b[5*y+(x+2)%5]);
    a[0] = a[0] ^ {rc[6], 31'b0, rc[5], 15'b0, rc[4], 7'b0, rc[3], 3'b0, rc[2], 1'b0, rc[1], rc[0]};
    for (int i = 0; i < 25; i++) r[1599-64*i -: 64] = a[i];
    return r;
  endfunction

  fsm_t          fsm, fsm_next;
  logic [1599:0] state_q;
  logic [1599:0] load_value;
  logic [1599:0] chain [UNROLL+1];
  logic          last_step;

  assign chain[0] = state_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    logic [4:0] idx;
    assign idx          = round_idx + 5'(k);
    assign chain[k+1]   = keccak_round(chain[k], rc_rom(idx));
  end

  assign last_step = (round_idx + 5'(UNROLL)) == 5'd24;

`ifdef KECCAK_XOR_IN_EN
  assign load_value = state_q ^ in_state;
`else
  assign load_value = in_state;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (in_valid)  fsm_next = RUN;
      RUN:     if (last_step) fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm == IDLE);
    busy      = (fsm == RUN);
    out_valid = (fsm == DONE);
  end

  // NOTE: the wide state register is reset on purpose: rst must discard any partial permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      round_idx <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q   <= load_value;
            round_idx <= '0;
          end else if (clear) begin
            state_q <= '0;
          end
        end
        RUN: begin
          state_q   <= chain[UNROLL];
          round_idx <= last_step ? 5'd0 : round_idx + 5'(UNROLL);
        end
        default: ;
      endcase
    end
  end

  assign out_state = state_q;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench for keccak_round_ctrl: one DUT per legal UNROLL, instance 0 (UNROLL=1) carries the detailed sequence.
module tb_keccak_round_ctrl;
  localparam int N = 7;
  localparam int UV [N] = '{1, 2, 3, 4, 6, 8, 12};
  localparam logic [63:0] Z0 = 64'hF1258F7940E1DDE7;  // f(0) lane(0,0)
  localparam logic [63:0] Z1 = 64'h84D5CCF933C0478A;  // f(0) lane(1,0)
  localparam logic [63:0] Z2 = 64'h2D5C954DF96ECB3C;  // f(f(0)) lane(0,0)

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  out_ready = '0;
  logic          clear = 1'b0;
  logic [1599:0] in_state = '0;
  logic [N-1:0]  in_ready, out_valid, busy;
  logic [1599:0] out_state [N];
  logic [4:0]    ridx [N];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    keccak_round_ctrl #(.UNROLL(UV[g])) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .clear     (clear),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g]),
      .round_idx (ridx[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges after the accept edge until DUT 0 raises out_valid; -1 if the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid[0]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic accept0(input logic [1599:0] s, input logic clr);
    in_state    = s;
    clear       = clr;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    clear       = 1'b0;
  endtask

  initial begin
    logic [1599:0] res1;
    logic [1599:0] feed;
    int            lat;
    int            lat_v [N];

    // Reset state
    #12;
    check("rst_in_ready",  64'(in_ready[0]),  64'd1);
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_busy",      64'(busy[0]),      64'd0);
    check("rst_round_idx", 64'(ridx[0]),      64'd0);
    check("rst_lane0",     out_state[0][1599:1536], 64'd0);
    rst = 1'b0;
    tick();

    // Zero state into every UNROLL variant at once, out_ready held low
    for (int g = 0; g < N; g++) lat_v[g] = 0;
    in_state = '0;
    in_valid = '1;
    tick();
    in_valid = '0;
    check("run_busy",      64'(busy[0]),      64'd1);
    check("run_out_valid", 64'(out_valid[0]), 64'd0);
    check("run_in_ready",  64'(in_ready[0]),  64'd0);
    for (int c = 1; c <= 30; c++) begin
      tick();
      for (int g = 0; g < N; g++)
        if (out_valid[g] && lat_v[g] == 0) lat_v[g] = c;
    end
    for (int g = 0; g < N; g++) begin
      check($sformatf("lat_u%0d", UV[g]),   64'(lat_v[g]), 64'(24 / UV[g]));
      check($sformatf("lane0_u%0d", UV[g]), out_state[g][1599:1536], Z0);
      check($sformatf("lane1_u%0d", UV[g]), out_state[g][1535:1472], Z1);
    end

    // Backpressure on DUT 0: result must hold and in_valid pulses must be ignored
    out_ready = 7'b1111110;
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      in_state    = {25{64'hA5A5_0F0F_3C3C_9669 ^ 64'(i)}};
      tick();
      check("hold_out_valid", 64'(out_valid[0]), 64'd1);
      check("hold_in_ready",  64'(in_ready[0]),  64'd0);
      check("hold_lane0",     out_state[0][1599:1536], Z0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    check("release_out_valid", 64'(out_valid[0]), 64'd0);
    check("release_in_ready",  64'(in_ready[0]),  64'd1);
    check("retained_lane0",    out_state[0][1599:1536], Z0);
    res1 = out_state[0];

    // Second permutation: feed f(0) back, or absorb zero onto the retained f(0)
`ifdef KECCAK_XOR_IN_EN
    feed = '0;
`else
    feed = res1;
`endif
    accept0(feed, 1'b0);
    wait_done(lat);
    check("chain_lat",   64'(lat), 64'd24);
    check("chain_lane0", out_state[0][1599:1536], Z2);
    tick();
    check("one_done_out_valid", 64'(out_valid[0]), 64'd0);
    check("one_done_in_ready",  64'(in_ready[0]),  64'd1);

    // Clear in IDLE zeroes the state; clear during RUN is ignored
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_lane0", out_state[0][1599:1536], 64'd0);
    check("clear_lane1", out_state[0][1535:1472], 64'd0);
    accept0('0, 1'b0);
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_done(lat);
    check("run_clear_lat",   64'(lat), 64'd18);
    check("run_clear_lane0", out_state[0][1599:1536], Z0);
    check("run_clear_lane1", out_state[0][1535:1472], Z1);
    tick();

    // clear together with in_valid: the load wins
    accept0(feed, 1'b1);
    wait_done(lat);
    check("load_wins_lat",   64'(lat), 64'd24);
    check("load_wins_lane0", out_state[0][1599:1536], Z2);
    tick();

    // Reset in the middle of a run
    clear = 1'b1;
    tick();
    clear = 1'b0;
    accept0('0, 1'b0);
    repeat (11) tick();
    check("mid_round_idx", 64'(ridx[0]), 64'd11);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_in_ready",  64'(in_ready[0]),  64'd1);
    check("midrst_busy",      64'(busy[0]),      64'd0);
    check("midrst_round_idx", 64'(ridx[0]),      64'd0);
    check("midrst_lane0",     out_state[0][1599:1536], 64'd0);
    #2;
    rst = 1'b0;
    tick();
    check("postrst_out_valid", 64'(out_valid[0]), 64'd0);
    accept0('0, 1'b0);
    wait_done(lat);
    check("postrst_lat",   64'(lat), 64'd24);
    check("postrst_lane0", out_state[0][1599:1536], Z0);
    check("postrst_lane1", out_state[0][1535:1472], Z1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
